obi_amo_mem_responder: RTL



---
 rtl/obi_amo_mem_responder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/obi_amo_mem_responder.sv
// OBI responder over a flop-based word memory with LR/SC reservations and
// single-cycle read-modify-write AMOs. Includes the reduced OBI type package.

package obi_pkg;

  typedef logic [5:0] atop_t;

  typedef enum atop_t {
    ATOPNONE = 6'h00,
    AMOADD   = 6'h20,
    AMOSWAP  = 6'h21,
    ATOPLR   = 6'h22,
    ATOPSC   = 6'h23,
    AMOXOR   = 6'h24,
    AMOOR    = 6'h28,
    AMOAND   = 6'h2C,
    AMOMIN   = 6'h30,
    AMOMAX   = 6'h34,
    AMOMINU  = 6'h38,
    AMOMAXU  = 6'h3C
  } obi_atop_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_amo_mem_responder
  import obi_pkg::*;
#(
  parameter int unsigned NumWords = 16,
  localparam int unsigned AW = $clog2(NumWords)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  req_i,
  input  atop_t     atop_i,
  output obi_resp_t resp_o
);

  typedef enum logic {IDLE, AMO_EXEC} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [NumWords];
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;

  logic            resv_valid_q, resv_valid_d;
  logic [AW-1:0]   resv_idx_q, resv_idx_d;
  logic [AW-1:0]   amo_idx_q, amo_idx_d;
  logic [31:0]     amo_wdata_q, amo_wdata_d;
  obi_atop_e       amo_op_q, amo_op_d;

  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [AW-1:0]   req_idx;
  logic [31:0]     be_mask;
  logic [31:0]     amo_old;
  logic [31:0]     amo_new;
  logic            unused_addr_bits;

  assign req_idx = req_i.addr[AW+1:2];
  assign be_mask = {{8{req_i.be[3]}}, {8{req_i.be[2]}}, {8{req_i.be[1]}}, {8{req_i.be[0]}}};
  assign unused_addr_bits = ^{req_i.addr[31:AW+2], req_i.addr[1:0]};
  assign amo_old = mem_q[amo_idx_q];

  always_comb begin
    resp_o        = '0;
    resp_o.gnt    = (state_q == IDLE);
    resp_o.rvalid = rvalid_q;
    resp_o.rdata  = rdata_q;
  end

  always_comb begin
    amo_new = amo_wdata_q;
    unique case (amo_op_q)
      AMOADD:  amo_new = amo_old + amo_wdata_q;
      AMOXOR:  amo_new = amo_old ^ amo_wdata_q;
      AMOAND:  amo_new = amo_old & amo_wdata_q;
      AMOOR:   amo_new = amo_old | amo_wdata_q;
      AMOMIN:  amo_new = ($signed(amo_old) < $signed(amo_wdata_q)) ? amo_old : amo_wdata_q;
      AMOMAX:  amo_new = ($signed(amo_old) > $signed(amo_wdata_q)) ? amo_old : amo_wdata_q;
      AMOMINU: amo_new = (amo_old < amo_wdata_q) ? amo_old : amo_wdata_q;
      AMOMAXU: amo_new = (amo_old > amo_wdata_q) ? amo_old : amo_wdata_q;
      default: amo_new = amo_wdata_q;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    mem_we       = 1'b0;
    mem_widx     = req_idx;
    mem_wdata    = '0;
    resv_valid_d = resv_valid_q;
    resv_idx_d   = resv_idx_q;
    amo_idx_d    = amo_idx_q;
    amo_wdata_d  = amo_wdata_q;
    amo_op_d     = amo_op_q;

    unique case (state_q)
      IDLE: begin
        if (req_i.req) begin
          case (atop_i)
            ATOPLR: begin
              rvalid_d     = 1'b1;
              rdata_d      = mem_q[req_idx];
              resv_valid_d = 1'b1;
              resv_idx_d   = req_idx;
            end
            ATOPSC: begin
              rvalid_d     = 1'b1;
              resv_valid_d = 1'b0;
              if (resv_valid_q && (resv_idx_q == req_idx)) begin
                mem_we    = 1'b1;
                mem_wdata = req_i.wdata;
                rdata_d   = '0;
              end else begin
                rdata_d = 32'd1;
              end
            end
            AMOSWAP, AMOADD, AMOXOR, AMOAND, AMOOR,
            AMOMIN, AMOMAX, AMOMINU, AMOMAXU: begin
              amo_idx_d   = req_idx;
              amo_wdata_d = req_i.wdata;
              amo_op_d    = obi_atop_e'(atop_i);
              state_d     = AMO_EXEC;
            end
            default: begin
              rvalid_d = 1'b1;
              if (req_i.we) begin
                mem_we    = 1'b1;
                mem_wdata = (mem_q[req_idx] & ~be_mask) | (req_i.wdata & be_mask);
                rdata_d   = '0;
                if (resv_idx_q == req_idx) resv_valid_d = 1'b0;
              end else begin
                rdata_d = mem_q[req_idx];
              end
            end
          endcase
        end
      end
      AMO_EXEC: begin
        mem_we    = 1'b1;
        mem_widx  = amo_idx_q;
        mem_wdata = amo_new;
        rvalid_d  = 1'b1;
        rdata_d   = amo_old;
        if (resv_idx_q == amo_idx_q) resv_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
      amo_idx_q    <= '0;
      amo_wdata_q  <= '0;
      amo_op_q     <= AMOSWAP;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      resv_valid_q <= resv_valid_d;
      resv_idx_q   <= resv_idx_d;
      amo_idx_q    <= amo_idx_d;
      amo_wdata_q  <= amo_wdata_d;
      amo_op_q     <= amo_op_d;
    end
  end

  // NOTE: the memory is reset because software relies on an all-zero lock area after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

endmodule
